// File: rtl/f_ifq.sv
// rtl/f_ifq.sv - fetch-to-decode instruction queue holding PC/instruction pairs
// Circular buffer with a separate occupancy count; flush and reset empty it, no bypass.
module f_ifq #(
    parameter int DEPTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_con_flush,
    input  logic                       i_fetch_valid,
    input  logic [31:0]                i_fetch_pc,
    input  logic [31:0]                i_fetch_instr,
    output logic                       o_fetch_ready,
    output logic                       o_dec_valid,
    output logic [31:0]                o_dec_pc,
    output logic [31:0]                o_dec_instr,
    input  logic                       i_dec_ready,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          push, pop;

    // Ready depends only on registered occupancy, so a pop cannot free a slot for the same-cycle push.
    assign o_fetch_ready = (count_q != CW'(DEPTH));
    assign o_dec_valid   = (count_q != '0);
    assign o_count       = count_q;

    assign push = i_fetch_valid && o_fetch_ready && !i_con_flush;
    assign pop  = o_dec_valid && i_dec_ready && !i_con_flush;

    assign o_dec_pc    = o_dec_valid ? pc_mem[rd_ptr_q]    : 32'h0;
    assign o_dec_instr = o_dec_valid ? instr_mem[rd_ptr_q] : NOP_INSTR;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_con_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left unreset; the output mux masks any entry that is not valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= i_fetch_pc;
            instr_mem[wr_ptr_q] <= i_fetch_instr;
        end
    end

endmodule

// File: tb/tb_f_ifq.sv
// tb/tb_f_ifq.sv - self-checking bench for f_ifq
module tb_f_ifq;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          fvalid;
    logic [31:0]   fpc;
    logic [31:0]   finstr;
    logic          fready;
    logic          dvalid;
    logic [31:0]   dpc;
    logic [31:0]   dinstr;
    logic          dready;
    logic [CW-1:0] count;

    int errors = 0;
    int checks = 0;

    logic [31:0] mq_pc[$];
    logic [31:0] mq_in[$];

    f_ifq #(.DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_con_flush   (flush),
        .i_fetch_valid (fvalid),
        .i_fetch_pc    (fpc),
        .i_fetch_instr (finstr),
        .o_fetch_ready (fready),
        .o_dec_valid   (dvalid),
        .o_dec_pc      (dpc),
        .o_dec_instr   (dinstr),
        .i_dec_ready   (dready),
        .o_count       (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        fv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        dr;
        int          e_count;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_ready;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: a FIFO of pairs; accept only when not full before the edge, flush wins.
    task automatic model_edge();
        logic do_push;
        logic do_pop;
        if (flush) begin
            mq_pc.delete();
            mq_in.delete();
        end else begin
            do_push = fvalid && (mq_pc.size() < DEPTH);
            do_pop  = dready && (mq_pc.size() > 0);
            if (do_pop) begin
                void'(mq_pc.pop_front());
                void'(mq_in.pop_front());
            end
            if (do_push) begin
                mq_pc.push_back(fpc);
                mq_in.push_back(finstr);
            end
        end
    endtask

    task automatic check_model(input string tag);
        int n;
        n = mq_pc.size();
        check({tag, ".count"}, 32'(count), 32'(n));
        check({tag, ".dec_valid"}, 32'(dvalid), 32'(n != 0));
        check({tag, ".fetch_ready"}, 32'(fready), 32'(n != DEPTH));
        check({tag, ".dec_pc"}, dpc, (n != 0) ? mq_pc[0] : 32'h0);
        check({tag, ".dec_instr"}, dinstr, (n != 0) ? mq_in[0] : 32'h13);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic fl, input logic fv, input logic [31:0] pc,
                         input logic [31:0] ins, input logic dr);
        flush  = fl;
        fvalid = fv;
        fpc    = pc;
        finstr = ins;
        dready = dr;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #12;
        check("reset.count", 32'(count), 32'd0);
        check("reset.dec_valid", 32'(dvalid), 32'd0);
        check("reset.fetch_ready", 32'(fready), 32'd1);
        check("reset.dec_pc", dpc, 32'h0);
        check("reset.dec_instr", dinstr, 32'h13);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill, full-with-pop, flush-with-push, empty flush, push after flush.
        vecs.push_back('{1'b0, 1'b1, 32'h0, 32'hA, 1'b0, 1, 1'b1, 32'h0, 32'hA, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 32'h4, 32'hB, 1'b0, 2, 1'b1, 32'h0, 32'hA, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h8, 32'hC, 1'b0, 2, 1'b1, 32'h0, 32'hA, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h8, 32'hC, 1'b1, 1, 1'b1, 32'h4, 32'hB, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 32'hC, 32'hD, 1'b0, 2, 1'b1, 32'h4, 32'hB, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 32'h10, 32'hE, 1'b1, 0, 1'b0, 32'h0, 32'h13, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 0, 1'b0, 32'h0, 32'h13, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 32'h20, 32'hF, 1'b1, 1, 1'b1, 32'h20, 32'hF, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 0, 1'b0, 32'h0, 32'h13, 1'b1});
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].flush, vecs[i].fv, vecs[i].pc, vecs[i].instr, vecs[i].dr);
            cycle();
            check($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].e_count));
            check($sformatf("vec%0d.dec_valid", i), 32'(dvalid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d.dec_pc", i), dpc, vecs[i].e_pc);
            check($sformatf("vec%0d.dec_instr", i), dinstr, vecs[i].e_instr);
            check($sformatf("vec%0d.fetch_ready", i), 32'(fready), 32'(vecs[i].e_ready));
        end

        // Streaming: every push visible the following cycle, occupancy holds at one.
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 32'h100 + 32'(4 * i), $urandom, 1'b1);
            cycle();
            check($sformatf("stream%0d.pc", i), dpc, 32'h100 + 32'(4 * i));
            check($sformatf("stream%0d.count", i), 32'(count), 32'd1);
            check_model($sformatf("stream%0d", i));
        end
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        cycle();
        check_model("stream_flush");

        // Randomized traffic with occasional flush, checked against the queue model across wraps.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
                  $urandom, $urandom, $urandom_range(0, 1) == 1);
            cycle();
            check_model($sformatf("rand%0d", i));
        end

        // Asynchronous reset between edges with one entry held.
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        cycle();
        drive(1'b0, 1'b1, 32'h44, 32'h55, 1'b0);
        cycle();
        check("arst.pre_count", 32'(count), 32'd1);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.count", 32'(count), 32'd0);
        check("arst.dec_valid", 32'(dvalid), 32'd0);
        check("arst.fetch_ready", 32'(fready), 32'd1);
        check("arst.dec_pc", dpc, 32'h0);
        check("arst.dec_instr", dinstr, 32'h13);
        mq_pc.delete();
        mq_in.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 32'h200, 32'hC, 1'b0);
        cycle();
        check("arst.head_pc", dpc, 32'h200);
        check("arst.head_instr", dinstr, 32'hC);
        check("arst.head_count", 32'(count), 32'd1);
        check_model("arst_post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
